// File: rtl/fft_acc_mem_pkg.sv
// Shared constants and the byte-lane merge helper for the FFT accelerator dual-port RAM.
package fft_acc_mem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 13;

  // Legal READ_LATENCY range: 1 = array output, 2 = extra output register
  localparam int unsigned RL_MIN = 1;
  localparam int unsigned RL_MAX = 2;

  // Widest word the merge helper handles; callers widen/narrow with casts
  localparam int unsigned MERGE_W    = 256;
  localparam int unsigned MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(input logic [MERGE_W-1:0]    old_w,
                                                  input logic [MERGE_W-1:0]    new_w,
                                                  input logic [MERGE_BE_W-1:0] be);
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_acc_dpram_core.sv
// Byte-enabled true-dual-port array with read-before-write on both ports.
// Write enables arrive pre-arbitrated, so port A and B never target the same lane of one word.
module fft_acc_dpram_core
  import fft_acc_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter string       INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_rd_i,
  input  logic [ADDR_W-1:0]     a_addr_i,
  input  logic [DATA_W/8-1:0]   a_be_i,
  input  logic [DATA_W-1:0]     a_wdata_i,
  output logic [DATA_W-1:0]     a_rdata_o,
  input  logic                  b_rd_i,
  input  logic [ADDR_W-1:0]     b_addr_i,
  input  logic [DATA_W/8-1:0]   b_be_i,
  input  logic [DATA_W-1:0]     b_wdata_i,
  output logic [DATA_W-1:0]     b_rdata_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (b_be_i[i]) mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      if (a_be_i[i]) mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
    end
  end

  // Read registers capture the pre-write word and hold between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rd_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_rd_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/fft_acc_dpram_avmm.sv
// Dual Avalon-MM slave wrapper around the shared RAM: s1 for the Nios CPU, s2 for the FFT datapath.
// Adds clock-enable gating, same-port write forwarding, collision arbitration and a debug counter.
module fft_acc_dpram_avmm
  import fft_acc_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "fft_acc_dpram.hex",
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  input  logic              coll_clr,
  output logic [CNT_W-1:0]  coll_cnt
);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX || (DATA_W % 8) != 0 || DATA_W > MERGE_W)
  begin : g_bad_cfg
    $error("fft_acc_dpram_avmm: unsupported READ_LATENCY or DATA_W");
  end

  // Index 0 is s1, index 1 is s2 throughout
  logic                   ce_c, coll_c;
  logic [1:0]             rd_c, wr_c, rdv_c;
  logic [1:0][ADDR_W-1:0] addr_c;
  logic [1:0][BE_W-1:0]   be_c, wbe_c;
  logic [1:0][DATA_W-1:0] wdata_c, ram_rd, merged_c, rdata_c;
  logic [1:0][BE_W-1:0]   fwd_be_q;
  logic [1:0][DATA_W-1:0] fwd_data_q;
  logic [1:0]             v1_q;
  logic [CNT_W-1:0]       coll_cnt_q, coll_cnt_d;

  always_comb begin
    ce_c       = clken & ~reset_req;
    addr_c[0]  = s1_address;
    addr_c[1]  = s2_address;
    be_c[0]    = s1_byteenable;
    be_c[1]    = s2_byteenable;
    wdata_c[0] = s1_writedata;
    wdata_c[1] = s2_writedata;
    rd_c[0]    = ce_c & s1_chipselect & s1_read;
    rd_c[1]    = ce_c & s2_chipselect & s2_read;
    wr_c[0]    = ce_c & s1_chipselect & s1_write;
    wr_c[1]    = ce_c & s2_chipselect & s2_write;
    coll_c     = wr_c[0] & wr_c[1] & (addr_c[0] == addr_c[1]);
    // s1 owns every lane it enables on a collision; s2 keeps the rest
    wbe_c[0]   = wr_c[0] ? be_c[0] : '0;
    wbe_c[1]   = wr_c[1] ? (be_c[1] & ~(coll_c ? be_c[0] : '0)) : '0;
    for (int p = 0; p < 2; p++) begin
      merged_c[p] = DATA_W'(be_merge(MERGE_W'(ram_rd[p]), MERGE_W'(fwd_data_q[p]),
                                     MERGE_BE_W'(fwd_be_q[p])));
    end
  end

  fft_acc_dpram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_rd_i    (rd_c[0]),
    .a_addr_i  (addr_c[0]),
    .a_be_i    (wbe_c[0]),
    .a_wdata_i (wdata_c[0]),
    .a_rdata_o (ram_rd[0]),
    .b_rd_i    (rd_c[1]),
    .b_addr_i  (addr_c[1]),
    .b_be_i    (wbe_c[1]),
    .b_wdata_i (wdata_c[1]),
    .b_rdata_o (ram_rd[1])
  );

  // Remember what the own port wrote alongside each read so it can be merged over the old word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
      v1_q       <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rd_c[p]) begin
          fwd_be_q[p]   <= wr_c[p] ? be_c[p] : '0;
          fwd_data_q[p] <= wdata_c[p];
        end
      end
      if (ce_c) v1_q <= rd_c;
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic [1:0]             v2_q;
    logic [1:0][DATA_W-1:0] out_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q  <= '0;
        out_q <= '0;
      end else if (ce_c) begin
        v2_q <= v1_q;
        for (int p = 0; p < 2; p++) begin
          if (v1_q[p]) out_q[p] <= merged_c[p];
        end
      end
    end

    assign rdv_c   = v2_q & {2{ce_c}};
    assign rdata_c = out_q;
  end else begin : g_rl1
    assign rdv_c   = v1_q & {2{ce_c}};
    assign rdata_c = merged_c;
  end

  // Clear wins over a same-cycle collision; the count sticks at all-ones
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_clr) begin
      coll_cnt_d = '0;
    end else if (coll_c && (coll_cnt_q != {CNT_W{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coll_cnt_q <= '0;
    else          coll_cnt_q <= coll_cnt_d;
  end

  assign s1_readdata      = rdata_c[0];
  assign s2_readdata      = rdata_c[1];
  assign s1_readdatavalid = rdv_c[0];
  assign s2_readdatavalid = rdv_c[1];
  assign coll_cnt         = coll_cnt_q;

endmodule

// File: tb/tb_fft_acc_dpram_avmm.sv
// Bench for fft_acc_dpram_avmm: two instances (READ_LATENCY 1 and 2) share one stimulus stream
// and are checked every cycle against a queue-based transaction model, plus literal pins.
module tb_fft_acc_dpram_avmm;

  logic        clk = 1'b0;
  logic        reset_n, clken, reset_req, coll_clr;
  logic [9:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic        a_s1_v, a_s2_v, b_s1_v, b_s2_v;
  logic [3:0]  a_cnt, b_cnt;

  always #5 clk = ~clk;

  fft_acc_dpram_avmm #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1), .INIT_FILE(""), .CNT_W(4)) u_rl1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v),
    .coll_clr(coll_clr), .coll_cnt(a_cnt));

  fft_acc_dpram_avmm #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(2), .INIT_FILE(""), .CNT_W(4)) u_rl2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v),
    .coll_clr(coll_clr), .coll_cnt(b_cnt));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // ---------------- transaction model ----------------
  logic [31:0] mmem [1024];
  logic [31:0] dq [2][2][$];
  int          aq [2][2][$];
  logic [31:0] exp_rd [2][2];
  int          exp_cnt;
  logic [31:0] m_rd [2];
  logic        m_ce, m_coll;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          dq[i][p].delete();
          aq[i][p].delete();
          exp_rd[i][p] = '0;
        end
      exp_cnt = 0;
    end else begin
      m_ce   = clken && !reset_req;
      m_coll = m_ce && s1_chipselect && s1_write && s2_chipselect && s2_write && (s1_address == s2_address);
      if (coll_clr) exp_cnt = 0;
      else if (m_coll && exp_cnt < 15) exp_cnt++;
      if (m_ce) begin
        m_rd[0] = mmem[s1_address];
        if (s1_chipselect && s1_write) m_rd[0] = lanes(m_rd[0], s1_writedata, s1_byteenable);
        m_rd[1] = mmem[s2_address];
        if (s2_chipselect && s2_write) m_rd[1] = lanes(m_rd[1], s2_writedata, s2_byteenable);
        for (int i = 0; i < 2; i++)
          for (int p = 0; p < 2; p++) begin
            if (aq[i][p].size() > 0 && aq[i][p][0] == i + 1) begin
              void'(aq[i][p].pop_front());
              void'(dq[i][p].pop_front());
            end
            for (int k = 0; k < aq[i][p].size(); k++) aq[i][p][k] = aq[i][p][k] + 1;
            if (p == 0 ? (s1_chipselect && s1_read) : (s2_chipselect && s2_read)) begin
              aq[i][p].push_back(1);
              dq[i][p].push_back(m_rd[p]);
            end
            for (int k = 0; k < aq[i][p].size(); k++)
              if (aq[i][p][k] == i + 1) exp_rd[i][p] = dq[i][p][k];
          end
        // s1 applied last so it owns shared lanes
        if (s2_chipselect && s2_write) mmem[s2_address] = lanes(mmem[s2_address], s2_writedata, s2_byteenable);
        if (s1_chipselect && s1_write) mmem[s1_address] = lanes(mmem[s1_address], s1_writedata, s1_byteenable);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] dd [2][2];
  logic        dv [2][2];
  logic [3:0]  dc [2];
  always_comb begin
    dd[0][0] = a_s1_rd; dd[0][1] = a_s2_rd; dd[1][0] = b_s1_rd; dd[1][1] = b_s2_rd;
    dv[0][0] = a_s1_v;  dv[0][1] = a_s2_v;  dv[1][0] = b_s1_v;  dv[1][1] = b_s2_v;
    dc[0] = a_cnt; dc[1] = b_cnt;
  end

  logic [31:0] obs_d [2][2];
  int          obs_c [2][2];
  int          obs_n [2][2];
  logic [31:0] seq [$];
  logic        e_v;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        e_v = 1'b0;
        if (reset_n && clken && !reset_req)
          for (int k = 0; k < aq[i][p].size(); k++) if (aq[i][p][k] == i + 1) e_v = 1'b1;
        chk($sformatf("rdv rl%0d s%0d", i + 1, p + 1), 64'(dv[i][p]), 64'(e_v));
        chk($sformatf("readdata rl%0d s%0d", i + 1, p + 1), 64'(dd[i][p]),
            reset_n ? 64'(exp_rd[i][p]) : 64'd0);
        if (dv[i][p]) begin
          obs_d[i][p] = dd[i][p];
          obs_c[i][p] = cyc + 1;
          obs_n[i][p] = obs_n[i][p] + 1;
          if (i == 0 && p == 0) seq.push_back(dd[i][p]);
        end
      end
      chk($sformatf("coll_cnt rl%0d", i + 1), 64'(dc[i]), reset_n ? 64'(exp_cnt) : 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    coll_clr = 0;
  endtask

  task automatic p1(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
    s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic p2(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
    s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  int rd_cyc, base_a, base_b, base_b2, base_q;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin obs_d[i][p] = '0; obs_c[i][p] = 0; obs_n[i][p] = 0; end
    reset_n = 0; clken = 1; reset_req = 0;
    idle();
    repeat (3) tick();
    reset_n = 1;
    tick();
    chk("reset readdata", 64'(a_s1_rd), 64'd0);
    chk("reset coll_cnt", 64'(b_cnt), 64'd0);

    // T1: s1 write, s2 read back, latency per instance
    p1(0, 1, 10'h010, 32'hDEADBEEF, 4'hF); tick(); idle();
    p2(1, 0, 10'h010, 32'h0, 4'h0); tick(); rd_cyc = cyc; idle();
    repeat (3) tick();
    chk("t1 data rl1", 64'(obs_d[0][1]), 64'hDEADBEEF);
    chk("t1 data rl2", 64'(obs_d[1][1]), 64'hDEADBEEF);
    chk("t1 latency rl1", 64'(obs_c[0][1] - rd_cyc), 64'd1);
    chk("t1 latency rl2", 64'(obs_c[1][1] - rd_cyc), 64'd2);

    // T2: partial byte-enable overwrite
    p2(0, 1, 10'h040, 32'h11223344, 4'hF); tick();
    p2(0, 1, 10'h040, 32'hAABBCCDD, 4'h5); tick(); idle();
    p1(1, 0, 10'h040, 32'h0, 4'h0); tick(); idle();
    repeat (3) tick();
    chk("t2 merge rl1", 64'(obs_d[0][0]), 64'h11BB33DD);
    chk("t2 merge rl2", 64'(obs_d[1][0]), 64'h11BB33DD);

    // T3: write collision, counter, clear
    p1(0, 1, 10'h100, 32'h0, 4'hF); p2(0, 1, 10'h101, 32'h0, 4'hF); tick(); idle();
    p1(0, 1, 10'h100, 32'h000000FF, 4'h1); p2(0, 1, 10'h100, 32'h12345678, 4'h3); tick(); idle();
    chk("t3 coll_cnt", 64'(a_cnt), 64'd1);
    p2(1, 0, 10'h100, 32'h0, 4'h0); tick(); idle();
    repeat (3) tick();
    chk("t3 word rl1", 64'(obs_d[0][1]), 64'h000056FF);
    chk("t3 word rl2", 64'(obs_d[1][1]), 64'h000056FF);
    coll_clr = 1; tick(); idle();
    chk("t3 clr", 64'(b_cnt), 64'd0);
    for (int k = 0; k < 17; k++) begin
      p1(0, 1, 10'h101, 32'h1, 4'h1); p2(0, 1, 10'h101, 32'h2, 4'h1); tick();
    end
    idle();
    chk("t3 saturate rl1", 64'(a_cnt), 64'd15);
    chk("t3 saturate rl2", 64'(b_cnt), 64'd15);
    p1(0, 1, 10'h101, 32'h1, 4'h1); p2(0, 1, 10'h101, 32'h2, 4'h1); coll_clr = 1; tick(); idle();
    chk("t3 clr priority", 64'(a_cnt), 64'd0);

    // T4: streamed reads with a 3-cycle ce stall
    for (int k = 0; k < 8; k++) begin
      p1(0, 1, 10'(k), 32'hA5000000 | 32'(k), 4'hF); tick();
    end
    idle();
    base_a = obs_n[0][0]; base_b = obs_n[1][0]; base_q = seq.size();
    for (int k = 0; k < 8; k++) begin
      p1(1, 0, 10'(k), 32'h0, 4'h0);
      if (k == 4) begin
        clken = 0; repeat (3) tick(); clken = 1;
      end
      tick();
    end
    idle();
    repeat (4) tick();
    chk("t4 count rl1", 64'(obs_n[0][0] - base_a), 64'd8);
    chk("t4 count rl2", 64'(obs_n[1][0] - base_b), 64'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4 order %0d", k), 64'(seq[base_q + k]), 64'(32'hA5000000 | 32'(k)));

    // T5: same-port read+write forwarding vs cross-port old data
    p1(0, 1, 10'h020, 32'h0, 4'hF); tick(); idle();
    p1(1, 1, 10'h020, 32'hCAFEF00D, 4'hC); p2(1, 0, 10'h020, 32'h0, 4'h0); tick(); idle();
    repeat (3) tick();
    chk("t5 s1 fwd rl1", 64'(obs_d[0][0]), 64'hCAFE0000);
    chk("t5 s1 fwd rl2", 64'(obs_d[1][0]), 64'hCAFE0000);
    chk("t5 s2 old rl1", 64'(obs_d[0][1]), 64'h0);
    chk("t5 s2 old rl2", 64'(obs_d[1][1]), 64'h0);

    // reset_req blocks writes
    reset_req = 1; p1(0, 1, 10'h010, 32'h0, 4'hF); tick(); idle(); reset_req = 0;

    // T6: reset while two reads are in flight in the latency-2 instance
    base_b = obs_n[1][0]; base_b2 = obs_n[1][1];
    p1(1, 0, 10'h010, 32'h0, 4'h0); p2(1, 0, 10'h040, 32'h0, 4'h0); tick(); idle();
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1;
    repeat (4) tick();
    chk("t6 no valid s1", 64'(obs_n[1][0] - base_b), 64'd0);
    chk("t6 no valid s2", 64'(obs_n[1][1] - base_b2), 64'd0);
    chk("t6 rdata zero", 64'(b_s1_rd), 64'd0);
    p1(1, 0, 10'h010, 32'h0, 4'h0); p2(1, 0, 10'h040, 32'h0, 4'h0); tick(); idle();
    repeat (3) tick();
    chk("t6 kept 010", 64'(obs_d[1][0]), 64'hDEADBEEF);
    chk("t6 kept 040", 64'(obs_d[1][1]), 64'h11BB33DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
